// File: rtl/mrv1_wb_arb.sv
`default_nettype none
// ============================================================================
// mrv1_wb_arb : round-robin writeback arbiter feeding the RF write port
// Rev 1.0
// ============================================================================
module mrv1_wb_arb #(
   parameter  int DATA_WIDTH_P     = 32,
   parameter  int NUM_THREADS_P    = 4,
   parameter  int NUM_SRC_P        = 3,
   parameter  int REG_ADDR_WIDTH_P = 5,
   localparam int TID_W            = (NUM_THREADS_P > 1) ? $clog2(NUM_THREADS_P) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [NUM_SRC_P-1:0]                  src_valid_i,
   output logic [NUM_SRC_P-1:0]                  src_ready_o,
   input  logic [NUM_SRC_P*TID_W-1:0]            src_tid_i,
   input  logic [NUM_SRC_P*REG_ADDR_WIDTH_P-1:0] src_rd_addr_i,
   input  logic [NUM_SRC_P*DATA_WIDTH_P-1:0]     src_rd_data_i,
   input  logic                                  flush_i,
   input  logic [TID_W-1:0]                      flush_tid_i,
   output logic                                  rf_wr_en_o,
   output logic [TID_W-1:0]                      rf_wr_tid_o,
   output logic [REG_ADDR_WIDTH_P-1:0]           rf_wr_addr_o,
   output logic [DATA_WIDTH_P-1:0]               rf_wr_data_o,
   output logic                                  sb_clr_o,
   output logic [31:0]                           wb_count_o
);

   localparam int               PTR_W      = $clog2(NUM_SRC_P);
   localparam logic [PTR_W-1:0] LAST_SRC_C = PTR_W'(NUM_SRC_P - 1);

   logic [PTR_W-1:0]            rr_q, rr_d;
   logic                        wr_valid_q, wr_valid_d;
   logic [TID_W-1:0]            tid_q;
   logic [REG_ADDR_WIDTH_P-1:0] addr_q;
   logic [DATA_WIDTH_P-1:0]     data_q;
   logic [31:0]                 cnt_q;

   logic [NUM_SRC_P-1:0]        grant_w;
   logic [PTR_W-1:0]            gnt_idx_w;
   logic                        gnt_found_w;
   logic                        hs_w;
   logic [TID_W-1:0]            sel_tid_w;
   logic [REG_ADDR_WIDTH_P-1:0] sel_addr_w;
   logic [DATA_WIDTH_P-1:0]     sel_data_w;

   // Scan sources starting at rr_q, wrapping; first valid one wins.
   always_comb begin
      int idx;
      idx         = 0;
      grant_w     = '0;
      gnt_idx_w   = '0;
      gnt_found_w = 1'b0;
      for (int i = 0; i < NUM_SRC_P; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_SRC_P) idx = idx - NUM_SRC_P;
         if (!gnt_found_w && src_valid_i[idx]) begin
            gnt_found_w  = 1'b1;
            grant_w[idx] = 1'b1;
            gnt_idx_w    = PTR_W'(idx);
         end
      end
   end

   assign src_ready_o = reset_i ? '0 : grant_w;
   assign hs_w        = gnt_found_w & ~reset_i;

   always_comb begin
      sel_tid_w  = '0;
      sel_addr_w = '0;
      sel_data_w = '0;
      for (int i = 0; i < NUM_SRC_P; i++) begin
         if (grant_w[i]) begin
            sel_tid_w  = src_tid_i[i*TID_W +: TID_W];
            sel_addr_w = src_rd_addr_i[i*REG_ADDR_WIDTH_P +: REG_ADDR_WIDTH_P];
            sel_data_w = src_rd_data_i[i*DATA_WIDTH_P +: DATA_WIDTH_P];
         end
      end
   end

   // Writes to x0 and results of a thread flushed this cycle are consumed silently.
   assign wr_valid_d = hs_w && (sel_addr_w != '0) && !(flush_i && (sel_tid_w == flush_tid_i));

   always_comb begin
      rr_d = rr_q;
      if (hs_w) rr_d = (gnt_idx_w == LAST_SRC_C) ? '0 : gnt_idx_w + PTR_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rr_q       <= '0;
         wr_valid_q <= 1'b0;
         tid_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         cnt_q      <= '0;
      end else begin
         rr_q       <= rr_d;
         wr_valid_q <= wr_valid_d;
         if (hs_w) begin
            tid_q  <= sel_tid_w;
            addr_q <= sel_addr_w;
            data_q <= sel_data_w;
         end
         if (wr_valid_q && (cnt_q != 32'hFFFF_FFFF)) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign rf_wr_en_o   = wr_valid_q;
   assign sb_clr_o     = wr_valid_q;
   assign rf_wr_tid_o  = tid_q;
   assign rf_wr_addr_o = addr_q;
   assign rf_wr_data_o = data_q;
   assign wb_count_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mrv1_wb_arb.sv
`default_nettype none
// ============================================================================
// tb_mrv1_wb_arb : vector table + randomized run against a behavioural model
// Rev 1.0
// ============================================================================
module tb_mrv1_wb_arb;

   localparam int N  = 3;
   localparam int TW = 2;
   localparam int AW = 5;
   localparam int DW = 32;

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic [N-1:0]      src_valid_i;
   logic [N-1:0]      src_ready_o;
   logic [N*TW-1:0]   src_tid_i;
   logic [N*AW-1:0]   src_rd_addr_i;
   logic [N*DW-1:0]   src_rd_data_i;
   logic              flush_i;
   logic [TW-1:0]     flush_tid_i;
   logic              rf_wr_en_o;
   logic [TW-1:0]     rf_wr_tid_o;
   logic [AW-1:0]     rf_wr_addr_o;
   logic [DW-1:0]     rf_wr_data_o;
   logic              sb_clr_o;
   logic [31:0]       wb_count_o;

   always #5 clk_i = ~clk_i;

   mrv1_wb_arb #(
      .DATA_WIDTH_P    (DW),
      .NUM_THREADS_P   (4),
      .NUM_SRC_P       (N),
      .REG_ADDR_WIDTH_P(AW)
   ) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .src_valid_i  (src_valid_i),
      .src_ready_o  (src_ready_o),
      .src_tid_i    (src_tid_i),
      .src_rd_addr_i(src_rd_addr_i),
      .src_rd_data_i(src_rd_data_i),
      .flush_i      (flush_i),
      .flush_tid_i  (flush_tid_i),
      .rf_wr_en_o   (rf_wr_en_o),
      .rf_wr_tid_o  (rf_wr_tid_o),
      .rf_wr_addr_o (rf_wr_addr_o),
      .rf_wr_data_o (rf_wr_data_o),
      .sb_clr_o     (sb_clr_o),
      .wb_count_o   (wb_count_o)
   );

   int errors = 0;
   int checks = 0;

   // Behavioural model: pointer as an integer, output register as plain fields.
   int            m_rr;
   logic          m_wen;
   logic [TW-1:0] m_tid;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;
   logic [31:0]   m_cnt;

   typedef struct {
      logic          rst;
      logic [N-1:0]  valid;
      logic [N*TW-1:0] tid;
      logic [N*AW-1:0] addr;
      logic          flush;
      logic [TW-1:0] ftid;
      logic [N-1:0]  exp_ready;
      logic          exp_wen;
      logic [31:0]   exp_cnt;
   } vec_t;

   localparam int NV = 27;
   vec_t tbl[NV];

   function automatic vec_t row(logic rst, logic [N-1:0] valid, logic flush, logic [TW-1:0] ftid,
                                logic [N-1:0] er, logic ew, logic [31:0] ec);
      vec_t v;
      v.rst = rst; v.valid = valid; v.flush = flush; v.ftid = ftid;
      v.tid  = {2'd0, 2'd2, 2'd1};
      v.addr = {5'd3, 5'd7, 5'd4};
      v.exp_ready = er; v.exp_wen = ew; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int model_grant();
      if (reset_i) return -1;
      for (int off = 0; off < N; off++) begin
         int k;
         k = (m_rr + off) % N;
         if (src_valid_i[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_checks();
      int g;
      logic [N-1:0] er;
      g  = model_grant();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ready", 64'(src_ready_o), 64'(er));
      chk("wr_en", 64'(rf_wr_en_o), 64'(m_wen));
      chk("sb_clr", 64'(sb_clr_o), 64'(m_wen));
      chk("wr_tid", 64'(rf_wr_tid_o), 64'(m_tid));
      chk("wr_addr", 64'(rf_wr_addr_o), 64'(m_addr));
      chk("wr_data", 64'(rf_wr_data_o), 64'(m_data));
      chk("wb_count", 64'(wb_count_o), 64'(m_cnt));
   endtask

   task automatic advance();
      int g;
      g = model_grant();
      @(posedge clk_i);
      if (reset_i) begin
         m_rr = 0; m_wen = 1'b0; m_tid = '0; m_addr = '0; m_data = '0; m_cnt = '0;
      end else begin
         if (m_wen && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (g >= 0) begin
            m_tid  = src_tid_i[g*TW +: TW];
            m_addr = src_rd_addr_i[g*AW +: AW];
            m_data = src_rd_data_i[g*DW +: DW];
            m_wen  = (m_addr != 0) && !(flush_i && m_tid == flush_tid_i);
            m_rr   = (g + 1) % N;
         end else begin
            m_wen = 1'b0;
         end
      end
      @(negedge clk_i);
   endtask

   initial begin
      // rst valid flush ftid exp_ready exp_wen exp_cnt
      tbl[0]  = row(1, 3'b111, 0, 0, 3'b000, 0, 0);
      tbl[1]  = row(1, 3'b111, 0, 0, 3'b000, 0, 0);
      tbl[2]  = row(1, 3'b111, 0, 0, 3'b000, 0, 0);
      tbl[3]  = row(0, 3'b000, 0, 0, 3'b000, 0, 0);
      tbl[4]  = row(0, 3'b010, 0, 0, 3'b010, 0, 0);
      tbl[5]  = row(0, 3'b000, 0, 0, 3'b000, 1, 0);
      tbl[6]  = row(0, 3'b000, 0, 0, 3'b000, 0, 1);
      tbl[7]  = row(0, 3'b100, 0, 0, 3'b100, 0, 1);
      tbl[8]  = row(0, 3'b111, 0, 0, 3'b001, 1, 1);
      tbl[9]  = row(0, 3'b111, 0, 0, 3'b010, 1, 2);
      tbl[10] = row(0, 3'b111, 0, 0, 3'b100, 1, 3);
      tbl[11] = row(0, 3'b111, 0, 0, 3'b001, 1, 4);
      tbl[12] = row(0, 3'b000, 0, 0, 3'b000, 1, 5);
      tbl[13] = row(0, 3'b000, 0, 0, 3'b000, 0, 6);
      tbl[14] = row(0, 3'b001, 0, 0, 3'b001, 0, 6);
      tbl[14].addr = {5'd3, 5'd7, 5'd0};
      tbl[15] = row(0, 3'b000, 0, 0, 3'b000, 0, 6);
      tbl[16] = row(0, 3'b100, 1, 1, 3'b100, 0, 6);
      tbl[16].tid  = {2'd1, 2'd2, 2'd1};
      tbl[16].addr = {5'd5, 5'd7, 5'd4};
      tbl[17] = row(0, 3'b001, 0, 0, 3'b001, 0, 6);
      tbl[18] = row(0, 3'b000, 1, 1, 3'b000, 1, 6);
      tbl[19] = row(0, 3'b000, 0, 0, 3'b000, 0, 7);
      tbl[20] = row(0, 3'b010, 0, 0, 3'b010, 0, 7);
      tbl[21] = row(1, 3'b111, 0, 0, 3'b000, 1, 7);
      tbl[22] = row(0, 3'b111, 0, 0, 3'b001, 0, 0);
      tbl[23] = row(0, 3'b000, 0, 0, 3'b000, 1, 0);
      tbl[24] = row(0, 3'b000, 0, 0, 3'b000, 0, 1);
      tbl[25] = row(0, 3'b010, 1, 3, 3'b010, 0, 1);
      tbl[26] = row(0, 3'b000, 0, 0, 3'b000, 1, 1);

      m_rr = 0; m_wen = 1'b0; m_tid = '0; m_addr = '0; m_data = '0; m_cnt = '0;
      reset_i = 1'b1; src_valid_i = '1; flush_i = 1'b0; flush_tid_i = '0;
      src_tid_i = '0; src_rd_addr_i = '0;
      src_rd_data_i = {32'h2222_0000, 32'hDEAD_BEEF, 32'h1111_0000};
      @(posedge clk_i);
      @(negedge clk_i);

      for (int i = 0; i < NV; i++) begin
         reset_i       = tbl[i].rst;
         src_valid_i   = tbl[i].valid;
         src_tid_i     = tbl[i].tid;
         src_rd_addr_i = tbl[i].addr;
         flush_i       = tbl[i].flush;
         flush_tid_i   = tbl[i].ftid;
         #2;
         chk($sformatf("vec%0d_ready", i), 64'(src_ready_o), 64'(tbl[i].exp_ready));
         chk($sformatf("vec%0d_wen", i), 64'(rf_wr_en_o), 64'(tbl[i].exp_wen));
         chk($sformatf("vec%0d_cnt", i), 64'(wb_count_o), 64'(tbl[i].exp_cnt));
         if (i == 5) begin
            chk("single_tid", 64'(rf_wr_tid_o), 64'd2);
            chk("single_addr", 64'(rf_wr_addr_o), 64'd7);
            chk("single_data", 64'(rf_wr_data_o), 64'hDEAD_BEEF);
            chk("single_sbclr", 64'(sb_clr_o), 64'd1);
         end
         model_checks();
         advance();
      end

      for (int c = 0; c < 800; c++) begin
         reset_i     = ($urandom_range(0, 60) == 0);
         src_valid_i = N'($urandom);
         for (int s = 0; s < N; s++) begin
            src_tid_i[s*TW +: TW]     = TW'($urandom);
            src_rd_addr_i[s*AW +: AW] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
            src_rd_data_i[s*DW +: DW] = $urandom;
         end
         flush_i     = ($urandom_range(0, 2) == 0);
         flush_tid_i = TW'($urandom);
         #2;
         model_checks();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
